// File: rtl/adma_data_mover.sv
// ADMA transfer engine: moves one TRAN descriptor's words between system
// memory and the SD data FIFOs, with block-gap stops and a TFC pulse.
module adma_data_mover #(
    parameter int AW = 64,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [AW-1:0] dat_adr,
    input  logic [15:0]   dat_len,
    input  logic          dir,
    input  logic [11:0]   block_size,
    input  logic          stop_at_gap,
    input  logic          continue_req,
    input  logic          abort,
    output logic          busy,
    output logic          tfc,
    output logic          block_done,
    output logic          gap_stopped,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic          mem_ack,
    input  logic [DW-1:0] mem_rdata,
    output logic [DW-1:0] tx_data,
    output logic          tx_valid,
    input  logic          tx_ready,
    input  logic [DW-1:0] rx_data,
    input  logic          rx_valid,
    output logic          rx_ready
);

    typedef enum logic [2:0] {
        S_IDLE, S_RD, S_PUSH, S_POP, S_WR, S_ADV, S_GAP, S_DONE
    } state_t;

    state_t        state, state_nxt;
    logic [AW-1:0] addr;
    logic [16:0]   rem;
    logic [11:0]   cnt;
    logic [11:0]   bs;
    logic          dir_q;
    logic [DW-1:0] data;

    logic [16:0]   rem_nxt;
    logic [12:0]   cnt_nxt;
    logic          block_hit;
    logic [15:0]   len_al;
    state_t        word_st;
    logic          unused_bits;

    assign unused_bits = ^{dat_adr[1:0], dat_len[1:0]};

    assign len_al    = {dat_len[15:2], 2'b00};
    assign rem_nxt   = rem - 17'd4;
    assign cnt_nxt   = {1'b0, cnt} + 13'd4;
    assign block_hit = (bs != 12'd0) && (cnt_nxt == {1'b0, bs});
    assign word_st   = dir_q ? S_POP : S_RD;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
            addr  <= '0;
            rem   <= '0;
            cnt   <= '0;
            bs    <= '0;
            dir_q <= 1'b0;
            data  <= '0;
        end else begin
            state <= state_nxt;
            unique case (1'b1)
                (state == S_IDLE) && start: begin
                    addr  <= {dat_adr[AW-1:2], 2'b00};
                    // an aligned length of zero encodes a full 64 KiB
                    rem   <= (len_al == 16'd0) ? 17'h10000
                                               : {1'b0, len_al};
                    cnt   <= '0;
                    bs    <= block_size;
                    dir_q <= dir;
                end
                (state == S_RD) && mem_ack:
                    data <= mem_rdata;
                (state == S_POP) && rx_valid:
                    data <= rx_data;
                state == S_ADV: begin
                    rem  <= rem_nxt;
                    addr <= addr + AW'(4);
                    cnt  <= block_hit ? 12'd0 : cnt_nxt[11:0];
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (start) state_nxt = dir ? S_POP : S_RD;
            S_RD:   if (mem_ack) state_nxt = S_PUSH;
            S_PUSH: if (tx_ready) state_nxt = S_ADV;
            S_POP:  if (rx_valid) state_nxt = S_WR;
            S_WR:   if (mem_ack) state_nxt = S_ADV;
            S_ADV: begin
                if (rem_nxt == 17'd0)
                    state_nxt = S_DONE;
                else if (block_hit && stop_at_gap)
                    state_nxt = S_GAP;
                else
                    state_nxt = word_st;
            end
            S_GAP:  if (continue_req) state_nxt = word_st;
            S_DONE: state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
        if (abort && state != S_IDLE)
            state_nxt = S_IDLE;
    end

    always_comb begin
        busy        = state != S_IDLE;
        mem_req     = (state == S_RD) || (state == S_WR);
        mem_we      = state == S_WR;
        tx_valid    = state == S_PUSH;
        rx_ready    = state == S_POP;
        gap_stopped = state == S_GAP;
        tfc         = state == S_DONE;
        block_done  = (state == S_ADV) && block_hit;
        mem_addr    = addr;
        mem_wdata   = data;
        tx_data     = data;
    end

endmodule

// File: tb/tb_adma_data_mover.sv
// Scoreboard bench for adma_data_mover: directed descriptors, expected
// memory/FIFO/pulse events queued by stimulus and popped by a monitor.
module tb_adma_data_mover;
    localparam int AW = 64;
    localparam int DW = 32;

    localparam logic [2:0] K_RD  = 3'd0;
    localparam logic [2:0] K_WR  = 3'd1;
    localparam logic [2:0] K_TX  = 3'd2;
    localparam logic [2:0] K_BD  = 3'd3;
    localparam logic [2:0] K_TFC = 3'd4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset, start, dir, stop_at_gap, continue_req, abort;
    logic [AW-1:0] dat_adr;
    logic [15:0]   dat_len;
    logic [11:0]   block_size;
    logic          busy, tfc, block_done, gap_stopped;
    logic          mem_req, mem_we, mem_ack;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata, tx_data, rx_data;
    logic          tx_valid, tx_ready, rx_valid, rx_ready;
    logic          ack_en;
    logic [31:0]   rx_cnt = 32'd0;

    assign mem_ack   = mem_req & ack_en;
    assign mem_rdata = mem_addr[31:0] ^ 32'h5A5A_0000;
    assign rx_data   = 32'hC0DE_0000 + rx_cnt;

    always @(posedge clk)
        if (rx_valid && rx_ready) rx_cnt <= rx_cnt + 32'd1;

    adma_data_mover #(.AW(AW), .DW(DW)) dut (
        .clk(clk), .reset(reset), .start(start), .dat_adr(dat_adr),
        .dat_len(dat_len), .dir(dir), .block_size(block_size),
        .stop_at_gap(stop_at_gap), .continue_req(continue_req),
        .abort(abort), .busy(busy), .tfc(tfc), .block_done(block_done),
        .gap_stopped(gap_stopped), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack),
        .mem_rdata(mem_rdata), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_ready(rx_ready)
    );

    typedef struct packed {
        logic [2:0]  kind;
        logic [63:0] addr;
        logic [31:0] data;
    } ev_t;

    ev_t exp_q[$];
    int  vectors = 0;
    int  errors  = 0;

    function automatic ev_t ev(logic [2:0] k, logic [63:0] a, logic [31:0] d);
        ev_t e;
        e.kind = k;
        e.addr = a;
        e.data = d;
        return e;
    endfunction

    task automatic push_rd(input logic [63:0] a);
        exp_q.push_back(ev(K_RD, a, 32'd0));
        exp_q.push_back(ev(K_TX, 64'd0, a[31:0] ^ 32'h5A5A_0000));
    endtask

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] expv);
        vectors++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    // Monitor: at most one observable event can occur per cycle.
    always @(negedge clk) begin
        ev_t got;
        ev_t e;
        logic have;
        have = 1'b0;
        got  = '0;
        if (mem_req && mem_ack) begin
            got  = ev(mem_we ? K_WR : K_RD, mem_addr,
                      mem_we ? mem_wdata : 32'd0);
            have = 1'b1;
        end else if (tx_valid && tx_ready) begin
            got  = ev(K_TX, 64'd0, tx_data);
            have = 1'b1;
        end else if (block_done) begin
            got  = ev(K_BD, 64'd0, 32'd0);
            have = 1'b1;
        end else if (tfc) begin
            got  = ev(K_TFC, 64'd0, 32'd0);
            have = 1'b1;
        end
        if (have) begin
            vectors++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_event: got kind %0d addr %h data %h, expected none",
                         got.kind, got.addr, got.data);
            end else begin
                e = exp_q.pop_front();
                if (got !== e) begin
                    errors++;
                    $display("FAIL event: got kind %0d addr %h data %h, expected kind %0d addr %h data %h",
                             got.kind, got.addr, got.data, e.kind, e.addr, e.data);
                end
            end
        end
    end

    task automatic start_xfer(input logic [63:0] a, input logic [15:0] len,
                              input logic d, input logic [11:0] bsz);
        @(posedge clk); #1;
        dat_adr    = a;
        dat_len    = len;
        dir        = d;
        block_size = bsz;
        start      = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int limit,
                             output int gaps);
        int n;
        n    = 0;
        gaps = 0;
        @(negedge clk);
        while (busy && n < limit) begin
            if (gap_stopped) gaps++;
            n++;
            @(negedge clk);
        end
        if (busy) begin
            vectors++;
            errors++;
            $display("FAIL %s_timeout: busy still 1 after %0d cycles, required 0",
                     name, limit);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int gaps;
        int n;
        logic [63:0] base;
        reset = 1'b1; start = 1'b0; dir = 1'b0; stop_at_gap = 1'b0;
        continue_req = 1'b0; abort = 1'b0; dat_adr = '0; dat_len = '0;
        block_size = '0; ack_en = 1'b1; tx_ready = 1'b1; rx_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("reset_busy", {63'd0, busy}, 64'd0);
        chk("reset_ctrl", {58'd0, mem_req, tx_valid, rx_ready, tfc,
                           block_done, gap_stopped}, 64'd0);
        chk("reset_addr", mem_addr, 64'd0);

        // 1: four zero-wait reads pushed to the tx FIFO
        for (int i = 0; i < 4; i++) push_rd(64'h1000 + 64'(4 * i));
        exp_q.push_back(ev(K_TFC, 64'd0, 32'd0));
        start_xfer(64'h1003, 16'd16, 1'b0, 12'd0);
        @(negedge clk);
        chk("t1_busy_after_start", {63'd0, busy}, 64'd1);
        wait_idle("t1", 200, gaps);
        chk("t1_q_empty", 64'(exp_q.size()), 64'd0);

        // 2: card-to-host with rx data withheld for 5 cycles
        exp_q.push_back(ev(K_WR, 64'h2000, 32'hC0DE_0000));
        exp_q.push_back(ev(K_WR, 64'h2004, 32'hC0DE_0001));
        exp_q.push_back(ev(K_TFC, 64'd0, 32'd0));
        start_xfer(64'h2000, 16'd8, 1'b1, 12'd0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t2_rx_ready_held", {63'd0, rx_ready}, 64'd1);
            chk("t2_no_mem_req", {63'd0, mem_req}, 64'd0);
        end
        @(posedge clk); #1 rx_valid = 1'b1;
        wait_idle("t2", 200, gaps);
        rx_valid = 1'b0;
        chk("t2_q_empty", 64'(exp_q.size()), 64'd0);

        // 3: two 16-byte blocks with a gap stop after the first
        stop_at_gap = 1'b1;
        for (int i = 0; i < 4; i++) push_rd(64'h3000 + 64'(4 * i));
        exp_q.push_back(ev(K_BD, 64'd0, 32'd0));
        for (int i = 4; i < 8; i++) push_rd(64'h3000 + 64'(4 * i));
        exp_q.push_back(ev(K_BD, 64'd0, 32'd0));
        exp_q.push_back(ev(K_TFC, 64'd0, 32'd0));
        start_xfer(64'h3000, 16'd32, 1'b0, 12'd16);
        n = 0;
        @(negedge clk);
        while (!gap_stopped && n < 200) begin
            n++;
            @(negedge clk);
        end
        chk("t3_gap_reached", {63'd0, gap_stopped}, 64'd1);
        chk("t3_q_at_gap", 64'(exp_q.size()), 64'd10);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t3_gap_held", {63'd0, gap_stopped}, 64'd1);
            chk("t3_gap_no_mem", {62'd0, mem_req, tx_valid}, 64'd0);
        end
        @(posedge clk); #1 continue_req = 1'b1;
        @(posedge clk); #1 continue_req = 1'b0;
        wait_idle("t3", 200, gaps);
        chk("t3_no_second_gap", 64'(gaps), 64'd0);
        chk("t3_q_empty", 64'(exp_q.size()), 64'd0);
        stop_at_gap = 1'b0;

        // 4: dat_len 0 is 64 KiB; 512-byte blocks give 128 block_done pulses
        base = 64'h0000_00AB_0001_0000;
        for (int w = 0; w < 16384; w++) begin
            push_rd(base + 64'(4 * w));
            if ((w + 1) % 128 == 0) exp_q.push_back(ev(K_BD, 64'd0, 32'd0));
        end
        exp_q.push_back(ev(K_TFC, 64'd0, 32'd0));
        start_xfer(base, 16'd0, 1'b0, 12'd512);
        wait_idle("t4", 60000, gaps);
        chk("t4_q_empty", 64'(exp_q.size()), 64'd0);
        chk("t4_final_addr", mem_addr, base + 64'h10000);

        // 5: abort while a read waits for mem_ack
        ack_en = 1'b0;
        start_xfer(64'h5000, 16'd8, 1'b0, 12'd0);
        @(negedge clk);
        chk("t5_req_pending", {63'd0, mem_req}, 64'd1);
        @(posedge clk); #1 abort = 1'b1;
        @(posedge clk); #1 abort = 1'b0;
        @(negedge clk);
        chk("t5_req_dropped", {63'd0, mem_req}, 64'd0);
        chk("t5_busy_low", {63'd0, busy}, 64'd0);
        repeat (3) @(negedge clk);
        ack_en = 1'b1;
        push_rd(64'h6000);
        exp_q.push_back(ev(K_TFC, 64'd0, 32'd0));
        start_xfer(64'h6000, 16'd4, 1'b0, 12'd0);
        wait_idle("t5", 200, gaps);
        chk("t5_q_empty", 64'(exp_q.size()), 64'd0);

        // 6: reset while tx_valid waits, then a start while busy
        tx_ready = 1'b0;
        exp_q.push_back(ev(K_RD, 64'h7000, 32'd0));
        start_xfer(64'h7000, 16'd8, 1'b0, 12'd0);
        n = 0;
        @(negedge clk);
        while (!tx_valid && n < 50) begin
            n++;
            @(negedge clk);
        end
        chk("t6_in_push", {63'd0, tx_valid}, 64'd1);
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        chk("t6_rst_ctrl", {57'd0, busy, mem_req, tx_valid, rx_ready, tfc,
                            block_done, gap_stopped}, 64'd0);
        chk("t6_rst_addr", mem_addr, 64'd0);
        chk("t6_rst_data", {32'd0, tx_data}, 64'd0);
        tx_ready = 1'b1;
        exp_q.push_back(ev(K_WR, 64'h8000, 32'hC0DE_0002));
        exp_q.push_back(ev(K_WR, 64'h8004, 32'hC0DE_0003));
        exp_q.push_back(ev(K_TFC, 64'd0, 32'd0));
        start_xfer(64'h8000, 16'd8, 1'b1, 12'd0);
        @(negedge clk);
        start_xfer(64'h9000, 16'd4, 1'b0, 12'd0);
        @(posedge clk); #1 rx_valid = 1'b1;
        wait_idle("t6", 200, gaps);
        rx_valid = 1'b0;
        repeat (4) @(negedge clk);
        chk("t6_ignored_start", {63'd0, busy}, 64'd0);
        chk("t6_q_empty", 64'(exp_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
